// File: rtl/tc_trace_player.sv
// tc_trace_player: TileLink trace player issuing get/put block acquires with tag checks and latency statistics
module tc_trace_player #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 64,
  parameter int TAG_W = 4,
  parameter int BEATS = 8,
  parameter int N_XACT = 4,
  parameter int XID_W = 7,
  parameter int MXID_W = 2,
  parameter int CNT_W = 32,
  localparam int BW = $clog2(BEATS),
  localparam int SW = (N_XACT > 1) ? $clog2(N_XACT) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                trc_valid,
  output logic                trc_ready,
  input  logic [ADDR_W-1:0]   trc_addr,
  input  logic                trc_write,
  input  logic [TAG_W-1:0]    trc_tag,
  input  logic                trc_chk,
  input  logic                trc_last,
  output logic                acq_valid,
  input  logic                acq_ready,
  output logic [ADDR_W-1:0]   acq_addr_block,
  output logic [XID_W-1:0]    acq_xact_id,
  output logic [BW-1:0]       acq_addr_beat,
  output logic [2:0]          acq_a_type,
  output logic [DATA_W-1:0]   acq_data,
  output logic [TAG_W-1:0]    acq_tag,
  input  logic                gnt_valid,
  output logic                gnt_ready,
  input  logic [XID_W-1:0]    gnt_xact_id,
  input  logic [MXID_W-1:0]   gnt_mxact_id,
  input  logic [BW-1:0]       gnt_addr_beat,
  input  logic [3:0]          gnt_g_type,
  input  logic [TAG_W-1:0]    gnt_tag,
  output logic                fin_valid,
  input  logic                fin_ready,
  output logic [MXID_W-1:0]   fin_mxact_id,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    n_done,
  output logic [2*CNT_W-1:0]  lat_sum,
  output logic [CNT_W-1:0]    lat_max,
  output logic [CNT_W-1:0]    err_cnt
);
  typedef enum logic [2:0] {IDLE, GET, PUT, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic last_q, last_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [N_XACT-1:0] slot_busy_q, slot_busy_d, slot_wr_q, slot_wr_d, slot_chk_q, slot_chk_d;
  logic [N_XACT-1:0][TAG_W-1:0] slot_tag_q, slot_tag_d;
  logic [N_XACT-1:0][CNT_W-1:0] slot_start_q, slot_start_d;
  logic [N_XACT-1:0][BW-1:0] slot_cnt_q, slot_cnt_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [SW-1:0] a_id_q, a_id_d;
  logic [BW-1:0] a_beat_q, a_beat_d;
  logic a_wr_q, a_wr_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;
  logic fin_v_q, fin_v_d;
  logic [MXID_W-1:0] fin_m_q, fin_m_d;
  logic [CNT_W-1:0] n_done_q, n_done_d, lat_max_q, lat_max_d, err_q, err_d;
  logic [2*CNT_W-1:0] lat_sum_q, lat_sum_d;
  logic free_ok;
  logic [SW-1:0] free_idx, gs;
  logic slot_ok, final_beat, trc_fire, acq_fire, gnt_fire, unused_beat;
  logic [CNT_W-1:0] lat;

  assign trc_ready = state_q == IDLE && free_ok && !last_q;
  assign acq_valid = state_q == GET || state_q == PUT;
  assign gnt_ready = !fin_v_q;
  assign fin_valid = fin_v_q;
  assign fin_mxact_id = fin_m_q;
  assign acq_addr_block = a_addr_q;
  assign acq_xact_id = XID_W'(a_id_q);
  assign acq_addr_beat = a_beat_q;
  assign acq_a_type = a_wr_q ? 3'd3 : 3'd1;
  assign acq_data = DATA_W'({a_addr_q, a_beat_q});
  assign acq_tag = a_tag_q;
  assign busy = |slot_busy_q || acq_valid;
  assign done = state_q == DONE;
  assign n_done = n_done_q;
  assign lat_sum = lat_sum_q;
  assign lat_max = lat_max_q;
  assign err_cnt = err_q;
  assign trc_fire = trc_valid && trc_ready;
  assign acq_fire = acq_valid && acq_ready;
  assign gnt_fire = gnt_valid && gnt_ready;
  assign gs = gnt_xact_id[SW-1:0];
  assign slot_ok = {1'b0, gnt_xact_id} < (XID_W+1)'(N_XACT) && slot_busy_q[gs] &&
                   gnt_g_type == (slot_wr_q[gs] ? 4'd2 : 4'd4);
  assign final_beat = slot_wr_q[gs] || slot_cnt_q[gs] == BW'(BEATS-1);
  assign lat = cyc_q - slot_start_q[gs];
  assign unused_beat = ^gnt_addr_beat;

  // Lowest-index free slot for the next trace entry
  always_comb begin
    free_ok = 1'b0;
    free_idx = '0;
    for (int i = N_XACT-1; i >= 0; i--) begin
      if (!slot_busy_q[i]) begin
        free_ok = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  // Issue FSM, slot bookkeeping, grant sinking and statistics
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cyc_d = cyc_q + 1'b1;
    slot_busy_d = slot_busy_q;
    slot_wr_d = slot_wr_q;
    slot_chk_d = slot_chk_q;
    slot_tag_d = slot_tag_q;
    slot_start_d = slot_start_q;
    slot_cnt_d = slot_cnt_q;
    a_addr_d = a_addr_q;
    a_id_d = a_id_q;
    a_beat_d = a_beat_q;
    a_wr_d = a_wr_q;
    a_tag_d = a_tag_q;
    fin_v_d = fin_v_q;
    fin_m_d = fin_m_q;
    n_done_d = n_done_q;
    lat_sum_d = lat_sum_q;
    lat_max_d = lat_max_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (last_q) state_d = DRAIN;
        else if (trc_fire) begin
          slot_busy_d[free_idx] = 1'b1;
          slot_wr_d[free_idx] = trc_write;
          slot_chk_d[free_idx] = trc_chk;
          slot_tag_d[free_idx] = trc_tag;
          slot_cnt_d[free_idx] = '0;
          a_addr_d = trc_addr;
          a_id_d = free_idx;
          a_beat_d = '0;
          a_wr_d = trc_write;
          a_tag_d = trc_tag;
          last_d = trc_last;
          state_d = trc_write ? PUT : GET;
        end
      end
      GET, PUT: begin
        if (acq_fire) begin
          if (a_beat_q == '0) slot_start_d[a_id_q] = cyc_q;
          if (state_q == GET || a_beat_q == BW'(BEATS-1)) state_d = IDLE;
          else a_beat_d = a_beat_q + 1'b1;
        end
      end
      DRAIN: if (slot_busy_q == '0) state_d = DONE;
      default: ;
    endcase
    if (fin_v_q && fin_ready) fin_v_d = 1'b0;
    if (gnt_fire) begin
      if (!slot_ok) err_d = err_q + 1'b1;
      else begin
        slot_cnt_d[gs] = slot_cnt_q[gs] + 1'b1;
        if (!slot_wr_q[gs] && slot_chk_q[gs] && gnt_tag != slot_tag_q[gs]) err_d = err_q + 1'b1;
        if (final_beat) begin
          slot_busy_d[gs] = 1'b0;
          n_done_d = n_done_q + 1'b1;
          lat_sum_d = lat_sum_q + (2*CNT_W)'(lat);
          lat_max_d = lat > lat_max_q ? lat : lat_max_q;
          fin_v_d = 1'b1;
          fin_m_d = gnt_mxact_id;
        end
      end
    end
  end

  // State registers; reset abandons every outstanding transaction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q <= 1'b0;
      cyc_q <= '0;
      slot_busy_q <= '0;
      slot_wr_q <= '0;
      slot_chk_q <= '0;
      slot_tag_q <= '0;
      slot_start_q <= '0;
      slot_cnt_q <= '0;
      a_addr_q <= '0;
      a_id_q <= '0;
      a_beat_q <= '0;
      a_wr_q <= 1'b0;
      a_tag_q <= '0;
      fin_v_q <= 1'b0;
      fin_m_q <= '0;
      n_done_q <= '0;
      lat_sum_q <= '0;
      lat_max_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cyc_q <= cyc_d;
      slot_busy_q <= slot_busy_d;
      slot_wr_q <= slot_wr_d;
      slot_chk_q <= slot_chk_d;
      slot_tag_q <= slot_tag_d;
      slot_start_q <= slot_start_d;
      slot_cnt_q <= slot_cnt_d;
      a_addr_q <= a_addr_d;
      a_id_q <= a_id_d;
      a_beat_q <= a_beat_d;
      a_wr_q <= a_wr_d;
      a_tag_q <= a_tag_d;
      fin_v_q <= fin_v_d;
      fin_m_q <= fin_m_d;
      n_done_q <= n_done_d;
      lat_sum_q <= lat_sum_d;
      lat_max_q <= lat_max_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_tc_trace_player.sv
// tb_tc_trace_player: directed scoreboard bench for the trace player
module tb_tc_trace_player;
  localparam int AW = 26, DW = 64, TW = 4, XW = 7, MW = 2, CW = 32, BOUND = 300;
  logic clk = 1'b0, rstn = 1'b0;
  logic trc_valid = 1'b0, trc_ready, trc_write = 1'b0, trc_chk = 1'b0, trc_last = 1'b0;
  logic [AW-1:0] trc_addr = '0;
  logic [TW-1:0] trc_tag = '0;
  logic acq_valid, acq_ready = 1'b1;
  logic [AW-1:0] acq_addr_block;
  logic [XW-1:0] acq_xact_id;
  logic [2:0] acq_addr_beat, acq_a_type;
  logic [DW-1:0] acq_data;
  logic [TW-1:0] acq_tag;
  logic gnt_valid = 1'b0, gnt_ready;
  logic [XW-1:0] gnt_xact_id = '0;
  logic [MW-1:0] gnt_mxact_id = '0;
  logic [2:0] gnt_addr_beat = '0;
  logic [3:0] gnt_g_type = '0;
  logic [TW-1:0] gnt_tag = '0;
  logic fin_valid, fin_ready = 1'b1;
  logic [MW-1:0] fin_mxact_id;
  logic busy, done;
  logic [CW-1:0] n_done, lat_max, err_cnt;
  logic [2*CW-1:0] lat_sum;
  int vectors = 0, miscompares = 0, acq_fires = 0, fin_fires = 0;
  logic [127:0] acq_q[$];
  logic [MW-1:0] fin_q[$];

  always #5 clk = ~clk;

  tc_trace_player dut (
    .clk(clk), .rstn(rstn),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_addr(trc_addr), .trc_write(trc_write),
    .trc_tag(trc_tag), .trc_chk(trc_chk), .trc_last(trc_last),
    .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_addr_block(acq_addr_block),
    .acq_xact_id(acq_xact_id), .acq_addr_beat(acq_addr_beat), .acq_a_type(acq_a_type),
    .acq_data(acq_data), .acq_tag(acq_tag),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_xact_id(gnt_xact_id),
    .gnt_mxact_id(gnt_mxact_id), .gnt_addr_beat(gnt_addr_beat), .gnt_g_type(gnt_g_type),
    .gnt_tag(gnt_tag),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .fin_mxact_id(fin_mxact_id),
    .busy(busy), .done(done), .n_done(n_done), .lat_sum(lat_sum), .lat_max(lat_max),
    .err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no handshake within %0d cycles, got none expected one", name, BOUND);
  endtask

  function automatic logic [127:0] acq_pack(input logic [AW-1:0] a, input logic [XW-1:0] id,
      input logic [2:0] beat, input logic [2:0] typ, input logic [DW-1:0] data, input logic [TW-1:0] tag);
    return 128'({a, id, beat, typ, data, tag});
  endfunction

  // Acquire scoreboard monitor
  always @(negedge clk) begin
    if (rstn && acq_valid && acq_ready) begin
      acq_fires++;
      if (acq_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL acq_unexpected: got beat %0d of addr %0h expected no acquire", acq_addr_beat, acq_addr_block);
      end else
        check("acq_beat", acq_pack(acq_addr_block, acq_xact_id, acq_addr_beat, acq_a_type, acq_data, acq_tag),
              acq_q.pop_front());
    end
  end

  // Finish scoreboard monitor
  always @(negedge clk) begin
    if (rstn && fin_valid && fin_ready) begin
      fin_fires++;
      if (fin_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL fin_unexpected: got mxid %0d expected no finish", fin_mxact_id);
      end else check("fin_mxid", fin_mxact_id, fin_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    trc_valid = 1'b0;
    gnt_valid = 1'b0;
    acq_ready = 1'b1;
    acq_q.delete();
    fin_q.delete();
    acq_fires = 0;
    fin_fires = 0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic exp_acq(input logic [AW-1:0] a, input logic [XW-1:0] id, input logic wr, input logic [TW-1:0] tag);
    for (int k = 0; k < (wr ? 8 : 1); k++)
      acq_q.push_back(acq_pack(a, id, 3'(k), wr ? 3'd3 : 3'd1, (64'(a) << 3) | 64'(k), tag));
  endtask

  task automatic send_trc(input logic [AW-1:0] a, input logic wr, input logic [TW-1:0] tag, input logic chk, input logic last);
    int n = 0;
    trc_valid = 1'b1; trc_addr = a; trc_write = wr; trc_tag = tag; trc_chk = chk; trc_last = last;
    forever begin
      @(negedge clk);
      if (trc_ready) break;
      if (++n > BOUND) begin
        timeout("trc_handshake");
        break;
      end
    end
    tick(1);
    trc_valid = 1'b0;
  endtask

  task automatic send_gnt(input logic [XW-1:0] id, input logic [MW-1:0] mx, input logic [2:0] beat,
      input logic [3:0] typ, input logic [TW-1:0] tag);
    int n = 0;
    gnt_valid = 1'b1; gnt_xact_id = id; gnt_mxact_id = mx; gnt_addr_beat = beat; gnt_g_type = typ; gnt_tag = tag;
    forever begin
      @(negedge clk);
      if (gnt_ready) break;
      if (++n > BOUND) begin
        timeout("gnt_handshake");
        break;
      end
    end
    tick(1);
    gnt_valid = 1'b0;
  endtask

  task automatic get_grant(input logic [XW-1:0] id, input logic [MW-1:0] mx, input logic [TW-1:0] tag);
    fin_q.push_back(mx);
    for (int k = 0; k < 8; k++) send_gnt(id, mx, 3'(k), 4'd4, tag);
  endtask

  task automatic end_test();
    check("acq_q_empty", 128'(acq_q.size()), 0);
    check("fin_q_empty", 128'(fin_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_ctl", {acq_valid, fin_valid, gnt_ready, busy, done, trc_ready}, 6'b001001);
    check("reset_cnt", {n_done, err_cnt, lat_max, lat_sum}, 0);
    tick(1);

    exp_acq(26'h10, 0, 1'b0, 4'd5);
    send_trc(26'h10, 1'b0, 4'd5, 1'b1, 1'b1);
    get_grant(0, 2'd1, 4'd5);
    tick(5);
    check("get_n_done", n_done, 1);
    check("get_err", err_cnt, 0);
    check("get_fin_count", fin_fires, 1);
    check("get_done", {done, busy}, 2'b10);
    end_test();

    do_reset();
    exp_acq(26'h20, 0, 1'b1, 4'd3);
    fork
      send_trc(26'h20, 1'b1, 4'd3, 1'b0, 1'b1);
      begin
        int n = 0;
        forever begin
          @(posedge clk);
          if (acq_fires >= 4) break;
          if (++n > BOUND) begin
            timeout("put_first_beats");
            break;
          end
        end
        #1 acq_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("put_stall_hold", {acq_valid, acq_addr_beat, acq_data}, {1'b1, 3'd4, 64'h104});
        end
        @(posedge clk);
        #1 acq_ready = 1'b1;
      end
    join
    tick(6);
    check("put_all_beats", acq_fires, 8);
    fin_q.push_back(2'd2);
    send_gnt(0, 2'd2, 3'd0, 4'd2, 4'd0);
    tick(5);
    check("put_n_done", {n_done, err_cnt}, {32'd1, 32'd0});
    check("put_done", done, 1'b1);
    end_test();

    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_acq(26'h100 + 26'(i), XW'(i), 1'b0, 4'd0);
      send_trc(26'h100 + 26'(i), 1'b0, 4'd0, 1'b0, 1'b0);
    end
    tick(3);
    check("full_four_acq", acq_fires, 4);
    exp_acq(26'h104, 2, 1'b0, 4'd0);
    fork
      send_trc(26'h104, 1'b0, 4'd0, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_trc_ready", trc_ready, 1'b0);
        end
        tick(1);
        get_grant(2, 2'd0, 4'd0);
      end
    join
    tick(3);
    trc_valid = 1'b1; trc_addr = 26'h105; trc_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("full_again_ready", trc_ready, 1'b0);
    end
    tick(1);
    trc_valid = 1'b0;
    check("full_n_done", {n_done, busy}, {32'd1, 1'b1});
    end_test();

    do_reset();
    exp_acq(26'h30, 0, 1'b0, 4'd7);
    send_trc(26'h30, 1'b0, 4'd7, 1'b1, 1'b0);
    tick(2);
    fin_q.push_back(2'd3);
    for (int k = 7; k >= 0; k--) send_gnt(0, 2'd3, 3'(k), 4'd4, k == 4 ? 4'd6 : 4'd7);
    tick(3);
    check("chk_err_one", {n_done, err_cnt}, {32'd1, 32'd1});
    send_gnt(3, 2'd0, 3'd0, 4'd4, 4'd0);
    tick(3);
    check("free_id_err", {n_done, err_cnt, busy}, {32'd1, 32'd2, 1'b0});
    exp_acq(26'h31, 0, 1'b0, 4'd0);
    send_trc(26'h31, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(2);
    send_gnt(0, 2'd0, 3'd0, 4'd2, 4'd0);
    tick(3);
    check("type_err", {n_done, err_cnt, busy}, {32'd1, 32'd3, 1'b1});
    get_grant(0, 2'd1, 4'd0);
    tick(3);
    check("type_recover", {n_done, err_cnt, busy}, {32'd2, 32'd3, 1'b0});
    end_test();

    do_reset();
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      exp_acq(26'h40 + 26'(i), 0, 1'b0, 4'd0);
      send_trc(26'h40 + 26'(i), 1'b0, 4'd0, 1'b0, i == 9);
      forever begin
        @(negedge clk);
        if (acq_valid && acq_ready) break;
        if (++n > BOUND) begin
          timeout("lat_acq");
          break;
        end
      end
      @(posedge clk);
      tick(12);
      get_grant(0, MW'(i), 4'd0);
    end
    tick(5);
    check("lat_n_done", n_done, 10);
    check("lat_max", lat_max, 20);
    check("lat_sum", lat_sum, 200);
    check("lat_done", {done, err_cnt, 32'(fin_fires)}, {1'b1, 32'd0, 32'd10});
    end_test();

    do_reset();
    acq_ready = 1'b0;
    send_trc(26'h50, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(2);
    rstn = 1'b0;
    #1;
    check("midrun_ctl", {acq_valid, fin_valid, gnt_ready, busy, done, trc_ready}, 6'b001001);
    check("midrun_cnt", {n_done, err_cnt, lat_max, lat_sum}, 0);
    tick(1);
    rstn = 1'b1;
    acq_ready = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
